// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: buffers {op, A, B} commands in a FIFO, issues them to a
// registered 8-bit ALU with a one-cycle ena pulse, captures the result one
// cycle later and returns it on a valid/ready port tagged with the opcode.
// Optional feature macro: ALU_SEQ_STATS_EN (saturating op/flag counters).
`timescale 1ns/1ps
module alu_op_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_ena,
  input  logic [7:0] alu_y,
  input  logic       alu_flag,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_y,
  output logic       res_flag,
  output logic [2:0] res_op,
  output logic       busy,
  output logic [7:0] stat_ops,
  output logic [7:0] stat_flags
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, OUT} state_t;

  state_t      state, next;
  logic [15:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic        empty, full, push, pop, load;
  logic [15:0] cmd_word, head_word, load_word;
  logic        res_hs;

  // Opcode replaces A[2:0] on the ALU pins, so the low operand bits are dropped.
  logic        unused_a_low;
  assign unused_a_low = ^cmd_a[2:0];

  assign cmd_word  = {cmd_a[7:3], cmd_op, cmd_b};
  assign head_word = mem[rp[AW-1:0]];
  assign empty     = (wp == rp);
  assign full      = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign pop       = (state == ISSUE);
  assign alu_ena   = (state == ISSUE);
  assign res_valid = (state == OUT);
  assign res_hs    = (state == OUT) && res_ready;
  assign busy      = !empty || (state != IDLE);
  // An empty FIFO can only reach ISSUE from OUT via a same-cycle push: bypass it.
  assign load_word = empty ? cmd_word : head_word;

  // FIFO storage; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= cmd_word;
  end

  // FIFO pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

  // Next-state logic; load marks the cycle before ISSUE when ALU pins are set up
  always_comb begin
    next = state;
    load = 1'b0;
    case (state)
      IDLE:  if (!empty) begin next = ISSUE; load = 1'b1; end
      ISSUE: next = CAPT;
      CAPT:  next = OUT;
      OUT: begin
        if (res_ready) begin
          if (!empty || push) begin next = ISSUE; load = 1'b1; end
          else                next = IDLE;
        end
      end
      default: next = IDLE;
    endcase
  end

  // State register, ALU operand registers and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      alu_a    <= '0;
      alu_b    <= '0;
      res_y    <= '0;
      res_flag <= 1'b0;
      res_op   <= '0;
    end else begin
      state <= next;
      if (load) begin
        alu_a <= load_word[15:8];
        alu_b <= load_word[7:0];
      end
      if (state == CAPT) begin
        res_y    <= alu_y;
        res_flag <= alu_flag;
        res_op   <= alu_a[2:0];
      end
    end
  end

`ifdef ALU_SEQ_STATS_EN
  // Saturating completed-op and flag-set counters, stepped on result handshakes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ops   <= '0;
      stat_flags <= '0;
    end else if (res_hs) begin
      if (stat_ops != 8'hFF)                stat_ops   <= stat_ops + 8'd1;
      if (res_flag && stat_flags != 8'hFF)  stat_flags <= stat_flags + 8'd1;
    end
  end
`else
  logic unused_hs;
  assign unused_hs  = res_hs;
  assign stat_ops   = '0;
  assign stat_flags = '0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed table, fill/backpressure/reset
// sequences, then randomized traffic against an in-order result queue model.
`timescale 1ns/1ps
module tb_alu_op_sequencer;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_a, cmd_b;
  logic [7:0] alu_a, alu_b;
  logic       alu_ena;
  logic [7:0] alu_y = '0;
  logic       alu_flag = 1'b0;
  logic       res_valid, res_ready;
  logic [7:0] res_y;
  logic       res_flag;
  logic [2:0] res_op;
  logic       busy;
  logic [7:0] stat_ops, stat_flags;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ena(alu_ena), .alu_y(alu_y), .alu_flag(alu_flag), .res_valid(res_valid),
    .res_ready(res_ready), .res_y(res_y), .res_flag(res_flag), .res_op(res_op),
    .busy(busy), .stat_ops(stat_ops), .stat_flags(stat_flags)
  );

  // Registered ALU: returns {flag, y}
  function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b);
    case (a[2:0])
      3'b000:  alu_f = {1'b0, a} + {1'b0, b};
      3'b001:  alu_f = {1'b0, a & b};
      3'b010:  alu_f = {1'b0, a | b};
      3'b011:  alu_f = {1'b0, a ^ b};
      3'b100:  alu_f = {1'b0, a << b[2:0]};
      3'b101:  alu_f = {1'b0, a >> b[2:0]};
      3'b110:  alu_f = {1'b0, a} - {1'b0, b};
      default: alu_f = 9'h000;
    endcase
  endfunction

  always @(posedge clk) if (alu_ena) {alu_flag, alu_y} <= alu_f(alu_a, alu_b);

  int ena_cnt = 0;
  always @(posedge clk) if (alu_ena) ena_cnt <= ena_cnt + 1;

  int n_chk = 0, n_fail = 0;
  logic [11:0] expq[$];       // {op, flag, y} in acceptance order
  int st_ops = 0, st_flags = 0;
  logic       hold;
  logic [11:0] held;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Book-keep the handshakes of the coming edge, advance, then check hold stability
  task automatic step();
    logic [8:0]  r;
    logic [11:0] e;
    if (cmd_valid && cmd_ready) begin
      r = alu_f({cmd_a[7:3], cmd_op}, cmd_b);
      expq.push_back({cmd_op, r});
    end
    if (res_valid && res_ready) begin
      n_chk++;
      if (expq.size() == 0) begin
        n_fail++;
        $display("FAIL res_spurious: got result %0h with empty model queue", res_y);
      end else begin
        n_chk--;
        e = expq.pop_front();
        chk("res_y", res_y, e[7:0]);
        chk("res_flag", res_flag, e[8]);
        chk("res_op", res_op, e[11:9]);
        if (st_ops < 255) st_ops++;
        if (e[8] && st_flags < 255) st_flags++;
      end
    end
    hold = res_valid && !res_ready;
    held = {res_op, res_flag, res_y};
    tick();
    if (hold) begin
      chk("hold_valid", res_valid, 1);
      chk("hold_data", {res_op, res_flag, res_y}, held);
    end
  endtask

  task automatic check_stats(input string name);
`ifdef ALU_SEQ_STATS_EN
    chk({name, "_ops"}, stat_ops, st_ops);
    chk({name, "_flags"}, stat_flags, st_flags);
`else
    chk({name, "_ops0"}, stat_ops, 0);
    chk({name, "_flags0"}, stat_flags, 0);
`endif
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] a, b, xa, y;
    logic       f;
  } vec_t;
  vec_t tbl[5];

  initial begin
    int acc, e0, n;
    tbl[0] = '{op: 3'b000, a: 8'hF8, b: 8'h10, xa: 8'hF8, y: 8'h08, f: 1'b1};
    tbl[1] = '{op: 3'b110, a: 8'h20, b: 8'h21, xa: 8'h26, y: 8'h05, f: 1'b0};
    tbl[2] = '{op: 3'b110, a: 8'h00, b: 8'h01, xa: 8'h06, y: 8'h05, f: 1'b0};
    tbl[3] = '{op: 3'b110, a: 8'h00, b: 8'h07, xa: 8'h06, y: 8'hFF, f: 1'b1};
    tbl[4] = '{op: 3'b111, a: 8'h5A, b: 8'hC3, xa: 8'h5F, y: 8'h00, f: 1'b0};

    rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
    cmd_op = '0; cmd_a = '0; cmd_b = '0; hold = 1'b0; held = '0;
    tick(); tick();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_outs", {res_valid, alu_ena, busy, res_flag, res_op, res_y, alu_a, alu_b}, 0);
    chk("rst_stats", {stat_ops, stat_flags}, 0);
    rst = 1'b0;
    tick();

    // Directed table: single command, latency and pin values
    for (int i = 0; i < 5; i++) begin
      e0 = ena_cnt;
      cmd_op = tbl[i].op; cmd_a = tbl[i].a; cmd_b = tbl[i].b; cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      chk("t_ena_pre", alu_ena, 0);
      step();
      chk("t_ena", alu_ena, 1);
      chk("t_alu_a", alu_a, tbl[i].xa);
      chk("t_alu_b", alu_b, tbl[i].b);
      step();
      chk("t_capt", {alu_ena, res_valid}, 0);
      step();
      chk("t_valid", res_valid, 1);
      chk("t_res", {res_op, res_flag, res_y}, {tbl[i].op, tbl[i].f, tbl[i].y});
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      chk("t_done", {res_valid, busy}, 0);
      chk("t_one_pulse", ena_cnt - e0, 1);
    end
`ifdef ALU_SEQ_STATS_EN
    chk("tbl_stat_ops", stat_ops, 5);
    chk("tbl_stat_flags", stat_flags, 2);
`endif
    check_stats("tbl_stats");

    // Backpressure: 10 cycles held in OUT
    cmd_op = 3'b010; cmd_a = 8'h81; cmd_b = 8'h42; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 10) begin step(); n++; end
    chk("bp_reach_out", res_valid, 1);
    e0 = ena_cnt;
    repeat (10) step();
    chk("bp_no_ena", ena_cnt - e0, 0);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;

    // Fill: back-to-back pushes with the consumer stalled
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      cmd_valid = 1'b1; cmd_op = 3'(i); cmd_a = 8'($urandom); cmd_b = 8'($urandom);
      if (cmd_ready) acc++;
      step();
    end
    cmd_valid = 1'b0;
    chk("fill_accepted", acc, DEPTH + 1);
    chk("fill_ready_low", cmd_ready, 0);
    res_ready = 1'b1;
    n = 0;
    while ((expq.size() != 0 || busy) && n < 60) begin step(); n++; end
    chk("fill_drained", expq.size(), 0);
    chk("fill_idle", {busy, cmd_ready}, 2'b01);
    res_ready = 1'b0;

    // Reset while a command is in CAPT with two more queued
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1; cmd_op = 3'b000; cmd_a = 8'(i * 16); cmd_b = 8'h01;
      step();
    end
    cmd_valid = 1'b0;
    chk("mid_capt", {alu_ena, res_valid, busy}, 3'b001);
    rst = 1'b1;
    #1;
    chk("mid_rst_outs", {res_valid, busy, cmd_ready}, 3'b001);
    check_stats("mid_rst_stats_pre");
    expq.delete(); st_ops = 0; st_flags = 0; hold = 1'b0;
    chk("mid_rst_stats", {stat_ops, stat_flags}, 0);
    tick();
    rst = 1'b0;
    e0 = ena_cnt;
    repeat (10) tick();
    chk("mid_no_ena", ena_cnt - e0, 0);
    chk("mid_idle", {busy, res_valid}, 0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op = 3'($urandom); cmd_a = 8'($urandom); cmd_b = 8'($urandom);
      res_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    cmd_valid = 1'b0; res_ready = 1'b1;
    n = 0;
    while ((expq.size() != 0 || busy) && n < 100) begin step(); n++; end
    chk("rand_drained", expq.size(), 0);
    chk("rand_idle", busy, 0);
    check_stats("rand_stats");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
